dht11_responder: RTL and testbench
==================================

// Module: dht11_responder
// PURPOSE
// Bus-functional DHT11 sensor emulator: acts as the responder on the single-wire transmission line.
// Detects the host start pulse and answers with the 80/80 us handshake plus a 40-bit frame built from register inputs.
// Used on-board (second GPIO pin) and in benches as the far end of the DHT11 reader inside the sensor facade.
// PARAMETERS
// CLK_FREQ_HZ    50_000_000  clock frequency; CLK_FREQ_HZ/1_000_000 must be an integer >= 2
// MIN_START_US   18000       minimum host low time accepted as a start pulse
// RESP_DELAY_US  30          gap between host release and our response low
// ZERO_HIGH_US   26          high time encoding a 0 bit
// ONE_HIGH_US    70          high time encoding a 1 bit
// PORTS
// clock              in     1   system clock
// reset_n            in     1   asynchronous active-low reset
// transmission_line  inout  1   open-drain DHT11 line: driven 0 or released (Z), never driven 1
// enable             in     1   1 = respond to start pulses; 0 = line released, state forced IDLE
// hum_int            in     8   humidity integer byte
// hum_float          in     8   humidity fractional byte
// temp_int           in     8   temperature integer byte
// temp_float         in     8   temperature fractional byte
// corrupt_checksum   in     1   1 = transmitted checksum is inverted (error injection)
// busy               out    1   1 from start-pulse qualification until frame end/abort
// frame_done         out    1   one-cycle pulse after final 50 us low is released
// collision          out    1   one-cycle pulse when the line is low while we release it during a high phase
// BEHAVIOUR
// - Reset (async): line released, state IDLE, busy=0, frame_done=0, collision=0, counters cleared.
// - Line input passes a 2-flop synchronizer; all decisions use the synchronized value (+2 clocks latency).
// - Time base: prescaler emits 1-cycle us_tick every CLK_FREQ_HZ/1e6 clocks; phase counters count us_tick.
// - Prescaler and phase counter restart at every state entry, so phase durations are exact to -1 tick.
// - States / transitions:
//   IDLE: line released; sync line falls -> START_LOW (counter cleared).
//   START_LOW: counts host low; rises before MIN_START_US -> IDLE (glitch, no outputs);
//     reaching MIN_START_US -> WAIT_RELEASE, busy=1, snapshot of all 5 bytes taken that cycle.
//   WAIT_RELEASE: waits for sync line high (no timeout) -> RESP_DELAY.
//   RESP_DELAY: released RESP_DELAY_US -> RESP_LOW.
//   RESP_LOW: drive 0 for 80 us -> RESP_HIGH.
//   RESP_HIGH: release 80 us -> BIT_LOW, bit index 39.
//   BIT_LOW: drive 0 for 50 us -> BIT_HIGH.
//   BIT_HIGH: release ZERO_HIGH_US or ONE_HIGH_US per current bit; index 0 done -> END_LOW, else index-1 -> BIT_LOW.
//   END_LOW: drive 0 for 50 us -> IDLE, release, frame_done pulse, busy=0.
// - Frame: MSB first, hum_int, hum_float, temp_int, temp_float, checksum.
// - Checksum = (hum_int+hum_float+temp_int+temp_float) mod 256, XOR 8'hFF if corrupt_checksum; computed from snapshot.
// - Inputs changing after snapshot do not affect the frame in flight.
// - Collision: in RESP_HIGH or BIT_HIGH, sync line low for 2 consecutive us_ticks before the phase ends
//   -> collision pulse, release, busy=0, go IDLE (no frame_done).
// - enable=0 at any time: line released within 1 clock, state IDLE, busy=0, no pulses.
// - enable rising while host is already holding low: start measured from next falling edge only.
// - A new start pulse is only recognised from IDLE; host activity in other states is ignored except collision rule.
// TESTING
// 1. CLK_FREQ_HZ=50e6, MIN_START_US=18000, bytes 0x37,0x00,0x19,0x05: host low 18 ms, release -> low 80 us after 30 us, 40 bits, checksum 0x55, frame_done once.
// 2. Host low 10 ms then release -> no drive on line, busy stays 0, no pulses.
// 3. corrupt_checksum=1 with bytes 0xFF,0xFF,0xFF,0xFF -> checksum sent 0x03 (sum 0xFC inverted).
// 4. Bench forces line low 10 us into bit 5 high phase -> collision pulse, line released, busy=0, frame_done never.
// 5. Change temp_int 0x19->0x20 during bit 3 -> frame still carries 0x19; next frame carries 0x20.
// 6. reset_n low mid BIT_LOW, and separately enable=0 mid frame -> line Z immediately, busy=0; next valid start answered normally.

Source files
------------

// File: rtl/dht11_responder_if.sv
// Register-side bundle of the DHT11 responder: frame contents, control and status pulses.
// The single-wire transmission line stays a plain inout on the responder itself.
`timescale 1ns/1ps
interface dht11_responder_if;
   logic       enable;
   logic [7:0] hum_int;
   logic [7:0] hum_float;
   logic [7:0] temp_int;
   logic [7:0] temp_float;
   logic       corrupt_checksum;
   logic       busy;
   logic       frame_done;
   logic       collision;

   modport master (
      output enable, hum_int, hum_float, temp_int, temp_float, corrupt_checksum,
      input  busy, frame_done, collision
   );

   modport slave (
      input  enable, hum_int, hum_float, temp_int, temp_float, corrupt_checksum,
      output busy, frame_done, collision
   );
endinterface

// File: rtl/dht11_responder.sv
// Bus-functional DHT11 sensor: qualifies the host start pulse, answers with the 80/80 us
// handshake and a 40-bit frame, and only ever pulls the open-drain line low or releases it.
`timescale 1ns/1ps
module dht11_responder #(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int MIN_START_US  = 18000,
   parameter int RESP_DELAY_US = 30,
   parameter int ZERO_HIGH_US  = 26,
   parameter int ONE_HIGH_US   = 70
) (
   input  logic clock,
   input  logic reset_n,
   inout  wire  transmission_line,
   dht11_responder_if.slave bus
);

   localparam int TICK_DIV     = CLK_FREQ_HZ / 1_000_000;
   localparam int HANDSHAKE_US = 80;
   localparam int BIT_LOW_US   = 50;
   localparam int MAX_A        = (MIN_START_US > RESP_DELAY_US) ? MIN_START_US : RESP_DELAY_US;
   localparam int MAX_B        = (ONE_HIGH_US > ZERO_HIGH_US) ? ONE_HIGH_US : ZERO_HIGH_US;
   localparam int MAX_C        = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_US       = (MAX_C > HANDSHAKE_US) ? MAX_C : HANDSHAKE_US;
   localparam int CW           = $clog2(MAX_US + 1);
   localparam int PW           = $clog2(TICK_DIV);

   typedef enum logic [3:0] {
      IDLE, START_LOW, WAIT_RELEASE, RESP_DELAY, RESP_LOW,
      RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            line_meta;
   logic            line_sync;
   logic            line_prev;
   logic [PW-1:0]   presc_cnt;
   logic [CW-1:0]   phase_cnt;
   logic [CW-1:0]   phase_len;
   logic            us_tick;
   logic            phase_end;
   logic            low_seen;
   logic            collide;
   logic [39:0]     frame;
   logic [5:0]      bit_idx;
   logic            cur_bit;
   logic            drive_low;
   logic [7:0]      checksum_now;

   // Never drive a 1; disabling releases the line without waiting for a clock edge.
   assign transmission_line = (drive_low && bus.enable) ? 1'b0 : 1'bz;

   assign us_tick      = (presc_cnt == PW'(TICK_DIV - 1));
   assign phase_end    = us_tick && (phase_cnt == phase_len - 1'b1);
   assign cur_bit      = frame[bit_idx];
   assign collide      = (state == RESP_HIGH || state == BIT_HIGH) && us_tick && !line_sync && low_seen;
   assign checksum_now = (bus.hum_int + bus.hum_float + bus.temp_int + bus.temp_float)
                         ^ {8{bus.corrupt_checksum}};

   always_comb begin
      phase_len = CW'(MIN_START_US);
      case (state)
         RESP_DELAY:       phase_len = CW'(RESP_DELAY_US);
         RESP_LOW,
         RESP_HIGH:        phase_len = CW'(HANDSHAKE_US);
         BIT_LOW, END_LOW: phase_len = CW'(BIT_LOW_US);
         BIT_HIGH:         phase_len = cur_bit ? CW'(ONE_HIGH_US) : CW'(ZERO_HIGH_US);
         default:          phase_len = CW'(MIN_START_US);
      endcase
   end

   // A collision in either high phase wins over that phase timing out in the same tick.
   always_comb begin
      next_state = state;
      if (!bus.enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:         if (line_prev && !line_sync) next_state = START_LOW;
            START_LOW:    if (line_sync) next_state = IDLE;
                          else if (phase_end) next_state = WAIT_RELEASE;
            WAIT_RELEASE: if (line_sync) next_state = RESP_DELAY;
            RESP_DELAY:   if (phase_end) next_state = RESP_LOW;
            RESP_LOW:     if (phase_end) next_state = RESP_HIGH;
            RESP_HIGH:    if (collide) next_state = IDLE;
                          else if (phase_end) next_state = BIT_LOW;
            BIT_LOW:      if (phase_end) next_state = BIT_HIGH;
            BIT_HIGH:     if (collide) next_state = IDLE;
                          else if (phase_end) next_state = (bit_idx == 6'd0) ? END_LOW : BIT_LOW;
            END_LOW:      if (phase_end) next_state = IDLE;
            default:      next_state = IDLE;
         endcase
      end
   end

   // Timebase and phase counters restart on every state entry so each phase is an exact
   // number of microseconds; low_seen remembers whether the previous tick already saw the line low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         line_meta      <= 1'b1;
         line_sync      <= 1'b1;
         line_prev      <= 1'b1;
         presc_cnt      <= '0;
         phase_cnt      <= '0;
         low_seen       <= 1'b0;
         frame          <= '0;
         bit_idx        <= '0;
         drive_low      <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.collision  <= 1'b0;
      end else begin
         line_meta      <= transmission_line;
         line_sync      <= line_meta;
         line_prev      <= line_sync;
         state          <= next_state;
         drive_low      <= (next_state == RESP_LOW) || (next_state == BIT_LOW) || (next_state == END_LOW);
         bus.frame_done <= 1'b0;
         bus.collision  <= 1'b0;

         if (next_state != state) begin
            presc_cnt <= '0;
            phase_cnt <= '0;
            low_seen  <= 1'b0;
         end else begin
            presc_cnt <= us_tick ? '0 : presc_cnt + 1'b1;
            if (us_tick) begin
               phase_cnt <= phase_cnt + 1'b1;
               low_seen  <= !line_sync;
            end
         end

         if (!bus.enable) begin
            bus.busy <= 1'b0;
         end else begin
            if (state == START_LOW && next_state == WAIT_RELEASE) begin
               bus.busy <= 1'b1;
               frame    <= {bus.hum_int, bus.hum_float, bus.temp_int, bus.temp_float, checksum_now};
            end
            if (collide) begin
               bus.collision <= 1'b1;
               bus.busy      <= 1'b0;
            end
            if (state == END_LOW && phase_end) begin
               bus.frame_done <= 1'b1;
               bus.busy       <= 1'b0;
            end
            if (state == RESP_HIGH) begin
               bit_idx <= 6'd39;
            end else if (state == BIT_HIGH && phase_end) begin
               bit_idx <= bit_idx - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dht11_responder.sv
// Acts as the DHT11 host: issues start pulses, decodes the responder's waveform by pulse
// widths and compares the recovered frame against a byte-level checksum model.
`timescale 1ns/1ps
module tb_dht11_responder;

   localparam int CLK_FREQ_HZ   = 2_000_000;
   localparam int K             = CLK_FREQ_HZ / 1_000_000;
   localparam int MIN_START_US  = 100;
   localparam int RESP_DELAY_US = 30;
   localparam int ZERO_HIGH_US  = 26;
   localparam int ONE_HIGH_US   = 70;
   localparam int SYNC_CLKS     = 3;
   localparam int LIMIT         = 40000;
   localparam int EV_NONE       = 0;
   localparam int EV_COLLIDE    = 1;
   localparam int EV_CHANGE     = 2;
   localparam int EV_RESET      = 3;
   localparam int EV_DISABLE    = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic host_low;
   wire  line;

   int checks = 0;
   int fails = 0;
   int frame_done_count = 0;
   int collision_count = 0;
   bit busy_seen = 1'b0;
   bit dut_drive_seen = 1'b0;

   dht11_responder_if bus ();

   pullup (line);
   assign line = host_low ? 1'b0 : 1'bz;

   dht11_responder #(
      .CLK_FREQ_HZ  (CLK_FREQ_HZ),
      .MIN_START_US (MIN_START_US),
      .RESP_DELAY_US(RESP_DELAY_US),
      .ZERO_HIGH_US (ZERO_HIGH_US),
      .ONE_HIGH_US  (ONE_HIGH_US)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .transmission_line(line),
      .bus              (bus)
   );

   always #250 clock = ~clock;

   // Pulse counters and "ever happened" flags, sampled away from the active edge.
   always @(negedge clock) begin
      if (bus.frame_done) frame_done_count++;
      if (bus.collision) collision_count++;
      if (bus.busy) busy_seen = 1'b1;
      if (!host_low && line === 1'b0) dut_drive_seen = 1'b1;
   end

   task automatic check_output(input string tag, input longint actual, input longint expected,
                               input longint tol);
      checks++;
      if (actual < expected - tol || actual > expected + tol) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, actual, expected, tol);
      end
   endtask

   function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d,
                                               input bit corrupt);
      int sum;
      logic [7:0] cs;
      sum = int'(a) + int'(b) + int'(c) + int'(d);
      cs  = 8'(sum % 256);
      if (corrupt) cs = 8'(255 - int'(cs));
      return {a, b, c, d, cs};
   endfunction

   task automatic measure(input logic lvl, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (line === lvl && n < LIMIT);
   endtask

   task automatic apply_stimulus(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti,
                                 input logic [7:0] tf, input bit corrupt, input int low_us);
      bus.hum_int          = hi;
      bus.hum_float        = hf;
      bus.temp_int         = ti;
      bus.temp_float       = tf;
      bus.corrupt_checksum = corrupt;
      @(negedge clock);
      host_low = 1'b1;
      repeat (low_us * K) @(negedge clock);
      check_output("busy_at_release", longint'(bus.busy), longint'(low_us > MIN_START_US), 0);
      host_low = 1'b0;
   endtask

   task automatic receive_frame(input logic [39:0] exp_frame, input int ev_bit, input int ev_kind,
                                output logic [39:0] data, output bit ok);
      int n;
      int fd0;
      int col0;
      ok   = 1'b0;
      data = '0;
      fd0  = frame_done_count;
      col0 = collision_count;
      measure(1'b1, n);
      check_output("resp_delay", n, RESP_DELAY_US * K + SYNC_CLKS, 1);
      if (n >= LIMIT) return;
      measure(1'b0, n);
      check_output("resp_low", n, 80 * K, 0);
      if (n >= LIMIT) return;
      measure(1'b1, n);
      check_output("resp_high", n, 80 * K, 0);
      if (n >= LIMIT) return;
      for (int i = 0; i < 40; i++) begin
         if (i == ev_bit && (ev_kind == EV_RESET || ev_kind == EV_DISABLE)) begin
            repeat (10 * K) @(negedge clock);
            check_output("driving_before_abort", longint'(line), 0, 0);
            if (ev_kind == EV_RESET) reset_n = 1'b0;
            else bus.enable = 1'b0;
            #1;
            check_output("line_released_on_abort", longint'(line), 1, 0);
            @(negedge clock);
            check_output("busy_after_abort", longint'(bus.busy), 0, 0);
            repeat (3) @(negedge clock);
            reset_n    = 1'b1;
            bus.enable = 1'b1;
            repeat (100 * K) @(negedge clock);
            check_output("no_pulses_after_abort",
                         (frame_done_count - fd0) + (collision_count - col0), 0, 0);
            return;
         end
         measure(1'b0, n);
         check_output($sformatf("bit%0d_low", i), n, 50 * K, 0);
         if (n >= LIMIT) return;
         if (i == ev_bit && ev_kind == EV_COLLIDE) begin
            repeat (10 * K) @(negedge clock);
            check_output("released_in_high", longint'(line), 1, 0);
            host_low = 1'b1;
            repeat (10 * K) @(negedge clock);
            check_output("collision_pulses", collision_count - col0, 1, 0);
            check_output("busy_on_collision", longint'(bus.busy), 0, 0);
            host_low       = 1'b0;
            dut_drive_seen = 1'b0;
            repeat (100 * K) @(negedge clock);
            check_output("silent_after_collision", longint'(dut_drive_seen), 0, 0);
            check_output("no_frame_done_on_collision", frame_done_count - fd0, 0, 0);
            return;
         end
         if (i == ev_bit && ev_kind == EV_CHANGE) bus.temp_int = 8'h20;
         measure(1'b1, n);
         check_output($sformatf("bit%0d_high", i), n,
                      exp_frame[39 - i] ? ONE_HIGH_US * K : ZERO_HIGH_US * K, 0);
         if (n >= LIMIT) return;
         data = {data[38:0], (n > (ZERO_HIGH_US + ONE_HIGH_US) * K / 2) ? 1'b1 : 1'b0};
      end
      measure(1'b0, n);
      check_output("end_low", n, 50 * K, 0);
      repeat (4) @(negedge clock);
      check_output("line_idle_after_frame", longint'(line), 1, 0);
      check_output("frame_done_once", frame_done_count - fd0, 1, 0);
      check_output("busy_after_frame", longint'(bus.busy), 0, 0);
      ok = 1'b1;
   endtask

   task automatic random_frame(input string tag);
      logic [7:0]  b [4];
      bit          corrupt;
      logic [39:0] exp_frame;
      logic [39:0] data;
      bit          ok;
      foreach (b[j]) b[j] = 8'($urandom_range(0, 255));
      corrupt   = 1'($urandom_range(0, 1));
      exp_frame = model_frame(b[0], b[1], b[2], b[3], corrupt);
      apply_stimulus(b[0], b[1], b[2], b[3], corrupt, 150);
      receive_frame(exp_frame, -1, EV_NONE, data, ok);
      check_output(tag, data, exp_frame, 0);
      repeat (20 * K) @(negedge clock);
   endtask

   initial begin
      logic [39:0] exp_frame;
      logic [39:0] data;
      bit          ok;
      int          fd0;
      int          col0;

      host_low             = 1'b0;
      reset_n              = 1'b0;
      bus.enable           = 1'b1;
      bus.hum_int          = '0;
      bus.hum_float        = '0;
      bus.temp_int         = '0;
      bus.temp_float       = '0;
      bus.corrupt_checksum = 1'b0;
      repeat (3) @(negedge clock);
      check_output("reset_busy", longint'(bus.busy), 0, 0);
      check_output("reset_frame_done", longint'(bus.frame_done), 0, 0);
      check_output("reset_collision", longint'(bus.collision), 0, 0);
      check_output("reset_line", longint'(line), 1, 0);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);

      $display("[TB] nominal frame");
      exp_frame = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      apply_stimulus(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 150);
      receive_frame(exp_frame, -1, EV_NONE, data, ok);
      check_output("frame_nominal", data, exp_frame, 0);
      check_output("checksum_nominal", data[7:0], 8'h55, 0);
      repeat (20 * K) @(negedge clock);

      $display("[TB] short host pulse");
      fd0            = frame_done_count;
      col0           = collision_count;
      busy_seen      = 1'b0;
      dut_drive_seen = 1'b0;
      apply_stimulus(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 50);
      repeat (200 * K) @(negedge clock);
      check_output("glitch_busy", longint'(busy_seen), 0, 0);
      check_output("glitch_drive", longint'(dut_drive_seen), 0, 0);
      check_output("glitch_pulses", (frame_done_count - fd0) + (collision_count - col0), 0, 0);

      $display("[TB] corrupted checksum");
      exp_frame = model_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      apply_stimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 150);
      receive_frame(exp_frame, -1, EV_NONE, data, ok);
      check_output("frame_corrupt", data, exp_frame, 0);
      check_output("checksum_corrupt", data[7:0], 8'h03, 0);
      repeat (20 * K) @(negedge clock);

      $display("[TB] collision in bit 5 high phase");
      exp_frame = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      apply_stimulus(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 150);
      receive_frame(exp_frame, 5, EV_COLLIDE, data, ok);
      repeat (20 * K) @(negedge clock);

      $display("[TB] inputs change mid frame");
      exp_frame = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      apply_stimulus(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 150);
      receive_frame(exp_frame, 3, EV_CHANGE, data, ok);
      check_output("frame_snapshot", data, exp_frame, 0);
      repeat (20 * K) @(negedge clock);
      exp_frame = model_frame(8'h37, 8'h00, 8'h20, 8'h05, 1'b0);
      apply_stimulus(8'h37, 8'h00, 8'h20, 8'h05, 1'b0, 150);
      receive_frame(exp_frame, -1, EV_NONE, data, ok);
      check_output("frame_after_change", data, exp_frame, 0);
      check_output("temp_int_after_change", data[23:16], 8'h20, 0);
      repeat (20 * K) @(negedge clock);

      $display("[TB] reset mid bit low");
      apply_stimulus(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 150);
      receive_frame(exp_frame, 10, EV_RESET, data, ok);
      random_frame("frame_after_reset");

      $display("[TB] disable mid frame");
      apply_stimulus(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 150);
      receive_frame(model_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0), 20, EV_DISABLE, data, ok);
      random_frame("frame_after_disable");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
